// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch next-PC unit and its F/D register.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        REFILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } fd_payload_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC choice: word-aligned BTB target when predicted taken, else PC+4.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        btb_pnif,
    output logic        taken,
    output logic [31:0] next_pc
);

    always_comb begin
        taken   = btb_hit & ~btb_pnif;
        // PC+4 wraps modulo 2^32 by construction of the 32-bit sum.
        next_pc = taken ? (btb_target & ALIGN_MASK) : (pc + PC_STEP);
    end

endmodule

// File: rtl/fetch_pc_sel.sv
// Fetch PC register, BTB-driven next-PC selection and F/D pipeline register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/redirect counters.
module fetch_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        imem_ready,
    input  logic [31:0] instr_in,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        btb_pnif,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
`endif
    output logic [31:0] pcF,
    output logic [31:0] pcD,
    output logic [31:0] instrD,
    output logic        validD,
    output logic        pred_takenD,
    output logic [31:0] pred_pcD,
    output logic        pnifD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fd_payload_t  fd_q, fd_d;
    logic         taken;
    logic [31:0]  next_pc;

    fetch_next_pc u_next_pc (
        .pc        (pc_q),
        .btb_hit   (btb_hit),
        .btb_target(btb_target),
        .btb_pnif  (btb_pnif),
        .taken     (taken),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fd_d    = fd_q;
        // A redirect wins in every state, so a stalled mispredict is never dropped.
        if (redirect_valid) begin
            pc_d         = redirect_pc & ALIGN_MASK;
            fd_d.valid   = 1'b0;
            fd_d.instr   = NOP_INSTR;
            state_d      = REFILL;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                REFILL: begin
                    fd_d.valid = 1'b0;
                    fd_d.instr = NOP_INSTR;
                    state_d    = RUN;
                end
                RUN: begin
                    if (stallF) begin
                        fd_d = fd_q;
                    end else if (!imem_ready) begin
                        fd_d.valid = 1'b0;
                        fd_d.instr = NOP_INSTR;
                    end else begin
                        fd_d.pc         = pc_q;
                        fd_d.instr      = instr_in;
                        fd_d.valid      = 1'b1;
                        fd_d.pred_taken = taken;
                        fd_d.pred_pc    = next_pc;
                        pc_d            = next_pc;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fd_q    <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0,
                         pred_taken: 1'b0, pred_pc: 32'd0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fd_q    <= fd_d;
        end
    end

    assign pcF         = pc_q;
    assign pcD         = fd_q.pc;
    assign instrD      = fd_q.instr;
    assign validD      = fd_q.valid;
    assign pred_takenD = fd_q.pred_taken;
    assign pred_pcD    = fd_q.pred_pc;
    assign pnifD       = ~fd_q.pred_taken;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic        capture;

    always_comb begin
        capture          = (state_q == RUN) & ~redirect_valid & ~stallF & imem_ready;
        perf_fetched_d   = perf_fetched_q;
        perf_redirects_d = perf_redirects_q;
        if (capture && perf_fetched_q != 32'hFFFF_FFFF)
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (redirect_valid && perf_redirects_q != 32'hFFFF_FFFF)
            perf_redirects_d = perf_redirects_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q   <= 32'd0;
            perf_redirects_q <= 32'd0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_pc_sel.sv
// Self-checking bench for fetch_pc_sel: directed vector table, random run vs model, async reset.
module tb_fetch_pc_sel;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF, imem_ready, btb_hit, btb_pnif, redirect_valid;
    logic [31:0] instr_in, btb_target, redirect_pc;
    logic [31:0] pcF, pcD, instrD, pred_pcD;
    logic        validD, pred_takenD, pnifD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_redirects;
`endif

    int npass = 0;
    int ntot  = 0;

    fetch_pc_sel #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(rst_n), .stallF(stallF), .imem_ready(imem_ready),
        .instr_in(instr_in), .btb_hit(btb_hit), .btb_target(btb_target),
        .btb_pnif(btb_pnif), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_redirects(perf_redirects),
`endif
        .pcF(pcF), .pcD(pcD), .instrD(instrD), .validD(validD),
        .pred_takenD(pred_takenD), .pred_pcD(pred_pcD), .pnifD(pnifD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, ready, hit, pnif, rv;
        logic [31:0] instr, target, rpc;
        logic [31:0] e_pcF, e_pcD, e_instrD, e_ppc;
        logic        e_valid, e_pt;
    } vec_t;

    vec_t vq[$];

    // Behavioural reference: architectural fetch PC, decode slot, one pending bubble flag.
    logic [31:0] m_pc, m_pcD, m_instr, m_ppc, m_fetched, m_redirs;
    logic        m_valid, m_pt;
    int          m_bubble;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic add_vec(input logic st, rd, input logic [31:0] ins, input logic h,
                           input logic [31:0] tg, input logic pn, rv, input logic [31:0] rp,
                           input logic [31:0] epc, epd, eins, input logic ev, ept,
                           input logic [31:0] eppc);
        vec_t v;
        v.stall = st; v.ready = rd; v.instr = ins; v.hit = h; v.target = tg;
        v.pnif = pn; v.rv = rv; v.rpc = rp; v.e_pcF = epc; v.e_pcD = epd;
        v.e_instrD = eins; v.e_valid = ev; v.e_pt = ept; v.e_ppc = eppc;
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, rd, input logic [31:0] ins, input logic h,
                         input logic [31:0] tg, input logic pn, rv, input logic [31:0] rp);
        stallF = st; imem_ready = rd; instr_in = ins; btb_hit = h;
        btb_target = tg; btb_pnif = pn; redirect_valid = rv; redirect_pc = rp;
    endtask

    task automatic model_reset;
        m_pc = RPC; m_pcD = 0; m_instr = NOP; m_valid = 0; m_pt = 0; m_ppc = 0;
        m_bubble = 1; m_fetched = 0; m_redirs = 0;
    endtask

    // Applies the current inputs to the model: state after the next edge.
    task automatic model_step;
        logic        tk;
        logic [31:0] nx;
        tk = btb_hit && !btb_pnif;
        nx = tk ? {btb_target[31:2], 2'b00} : m_pc + 32'd4;
        if (redirect_valid) begin
            m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 0; m_instr = NOP;
            m_bubble = 1; m_redirs++;
        end else if (m_bubble > 0) begin
            m_valid = 0; m_instr = NOP; m_bubble = 0;
        end else if (stallF) begin
            // everything holds
        end else if (!imem_ready) begin
            m_valid = 0; m_instr = NOP;
        end else begin
            m_pcD = m_pc; m_instr = instr_in; m_valid = 1; m_pt = tk; m_ppc = nx;
            m_pc = nx; m_fetched++;
        end
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".pcF"},    pcF,    RPC);
        chk({tag, ".pcD"},    pcD,    32'd0);
        chk({tag, ".instrD"}, instrD, NOP);
        chk({tag, ".validD"}, {31'd0, validD},      32'd0);
        chk({tag, ".predT"},  {31'd0, pred_takenD}, 32'd0);
        chk({tag, ".predPC"}, pred_pcD, 32'd0);
        chk({tag, ".pnifD"},  {31'd0, pnifD},       32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".perfF"},  perf_fetched,   32'd0);
        chk({tag, ".perfR"},  perf_redirects, 32'd0);
`endif
    endtask

    initial begin
        // stall ready instr hit target pnif rv rpc | pcF pcD instrD valid pt ppc
        add_vec(0,1,32'hA0,  0,0,0, 0,0,            32'h100, 0,      NOP,    0,0,0);
        add_vec(0,1,32'hA100,0,0,0, 0,0,            32'h104, 32'h100,32'hA100,1,0,32'h104);
        add_vec(0,1,32'hA104,0,0,0, 0,0,            32'h108, 32'h104,32'hA104,1,0,32'h108);
        add_vec(0,1,32'hEE,  0,0,0, 1,32'h200,      32'h200, 32'h104,NOP,    0,0,0);
        add_vec(0,1,32'hEE,  0,0,0, 0,0,            32'h200, 32'h104,NOP,    0,0,0);
        add_vec(0,1,32'hB200,1,32'h341,0, 0,0,      32'h340, 32'h200,32'hB200,1,1,32'h340);
        add_vec(0,1,32'hEE,  0,0,0, 1,32'h200,      32'h200, 32'h200,NOP,    0,0,0);
        add_vec(0,1,32'hEE,  0,0,0, 0,0,            32'h200, 32'h200,NOP,    0,0,0);
        add_vec(0,1,32'hB201,1,32'h340,1, 0,0,      32'h204, 32'h200,32'hB201,1,0,32'h204);
        add_vec(1,1,32'hEE,  0,0,0, 1,32'h500,      32'h500, 32'h200,NOP,    0,0,0);
        add_vec(1,1,32'hEE,  0,0,0, 0,0,            32'h500, 32'h200,NOP,    0,0,0);
        add_vec(0,1,32'hC500,0,0,0, 0,0,            32'h504, 32'h500,32'hC500,1,0,32'h504);
        for (int i = 0; i < 3; i++)
            add_vec(1,1,32'hEE,0,0,0, 0,0,          32'h504, 32'h500,32'hC500,1,0,32'h504);
        for (int i = 0; i < 2; i++)
            add_vec(0,0,32'hEE,0,0,0, 0,0,          32'h504, 32'h500,NOP,    0,0,0);
        add_vec(0,1,32'hC504,0,0,0, 0,0,            32'h508, 32'h504,32'hC504,1,0,32'h508);
        add_vec(0,1,32'hEE,  0,0,0, 1,32'hFFFF_FFFF,32'hFFFF_FFFC,32'h504,NOP,0,0,0);
        add_vec(0,1,32'hEE,  0,0,0, 0,0,            32'hFFFF_FFFC,32'h504,NOP,0,0,0);
        add_vec(0,1,32'hDFFC,0,0,0, 0,0,            32'h0, 32'hFFFF_FFFC,32'hDFFC,1,0,32'h0);
        add_vec(0,1,32'hEE,  0,0,0, 1,32'h603,      32'h600, 32'hFFFF_FFFC,NOP,0,0,0);

        rst_n = 1'b1;
        do_reset();
        check_reset_vals("rst");

        foreach (vq[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vq[i].stall, vq[i].ready, vq[i].instr, vq[i].hit, vq[i].target,
                  vq[i].pnif, vq[i].rv, vq[i].rpc);
            @(posedge clk);
            @(negedge clk);
            chk({nm, ".pcF"},    pcF,    vq[i].e_pcF);
            chk({nm, ".pcD"},    pcD,    vq[i].e_pcD);
            chk({nm, ".instrD"}, instrD, vq[i].e_instrD);
            chk({nm, ".validD"}, {31'd0, validD}, {31'd0, vq[i].e_valid});
            if (vq[i].e_valid) begin
                chk({nm, ".predT"},  {31'd0, pred_takenD}, {31'd0, vq[i].e_pt});
                chk({nm, ".predPC"}, pred_pcD, vq[i].e_ppc);
                chk({nm, ".pnifD"},  {31'd0, pnifD}, {31'd0, ~vq[i].e_pt});
            end
        end

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80, $urandom,
                  $urandom_range(0, 99) < 40, tg, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 8, $urandom);
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk("rnd.pcF",    pcF,    m_pc);
            chk("rnd.pcD",    pcD,    m_pcD);
            chk("rnd.instrD", instrD, m_instr);
            chk("rnd.validD", {31'd0, validD}, {31'd0, m_valid});
            chk("rnd.noX",    {31'd0, $isunknown({pred_takenD, pred_pcD})}, 32'd0);
            if (m_valid) begin
                chk("rnd.predT",  {31'd0, pred_takenD}, {31'd0, m_pt});
                chk("rnd.predPC", pred_pcD, m_ppc);
                chk("rnd.pnifD",  {31'd0, pnifD}, {31'd0, ~m_pt});
            end
`ifdef FETCH_PERF_CNT_EN
            chk("rnd.perfF", perf_fetched,   m_fetched);
            chk("rnd.perfR", perf_redirects, m_redirs);
`endif
        end

        // Boot edge, 10 captures, two redirect+refill pairs, then async reset mid-cycle.
        do_reset();
        drive(0, 1, 32'h1234, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("seq.pcF", pcF, RPC + 32'd40);
        chk("seq.validD", {31'd0, validD}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 32'h1234, 0, 0, 0, 1, 32'h700);
            @(negedge clk);
            drive(0, 1, 32'h1234, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("seq.refill", {31'd0, validD}, 32'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("seq.perfF", perf_fetched,   32'd10);
        chk("seq.perfR", perf_redirects, 32'd2);
`endif
        @(negedge clk);
        chk("seq.newpath", {31'd0, validD}, 32'd1);
        chk("seq.newpcD",  pcD, 32'h700);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
